router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-level controller for the 1x3 router.
- Sequences the input register, the write-enable/valid synchronizer and the three destination FIFOs.
- Decodes the 2-bit header address, waits for the destination FIFO to drain, then steps header, payload and parity through the register into that FIFO.
- Handles FIFO-full stalls and destination soft resets.

Parameters:
- WAIT_LIMIT, 30: maximum cycles in WAIT_TILL_EMPTY before a drop. Used only with ROUTER_FSM_TIMEOUT_EN.
- TMR_W, 5: width of the wait counter. Must satisfy 2^TMR_W > WAIT_LIMIT.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  synchronous active-low reset
- pkt_valid  input  1  source is driving packet bytes; deasserts with the parity byte
- data_in  input  2  header address bits [1:0]; sampled in DECODE_ADDRESS
- fifo_full  input  1  full flag of the currently selected FIFO, from the synchronizer
- fifo_empty_0/1/2  input  1 each  empty flags of FIFOs 0..2
- soft_reset_0/1/2  input  1 each  per-FIFO 30-cycle read-timeout resets, from the synchronizer
- parity_done  input  1  register has captured the parity byte
- low_pkt_valid  input  1  register saw pkt_valid fall while in the full stall
- busy  output  1  stall the source
- detect_add  output  1  synchronizer latches the address
- lfd_state  output  1  load first data (header)
- ld_state  output  1  load payload
- laf_state  output  1  load after full
- full_state  output  1  in the FIFO-full stall
- write_enb_reg  output  1  write enable toward the synchronizer
- rst_int_reg  output  1  register clears its internal parity/low_pkt_valid state
- drop_pkt  output  1  one-cycle drop pulse; exists only with ROUTER_FSM_TIMEOUT_EN

Behaviour:
- Encoded state register. All outputs are Moore, decoded combinationally from state.
- Reset (rstn=0 at an edge): state=DECODE_ADDRESS, addr_q=0, timer=0.
  - detect_add=1; every other output 0; drop_pkt=0.
- addr_q captures data_in on the edge leaving DECODE_ADDRESS with pkt_valid=1 and data_in!=3.
  - empty_sel = fifo_empty_[addr_q]; srst_sel = soft_reset_[addr_q].
- Transition priority: rstn, then srst_sel (any state except DECODE_ADDRESS forces DECODE_ADDRESS next cycle), then the per-state rules below.
- Reset or soft reset mid-packet abandons the packet without flushing; the FIFO's own soft reset handles cleanup.
- DECODE_ADDRESS: detect_add=1, busy=0.
  - pkt_valid & data_in!=3 & fifo_empty_[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid & data_in!=3 & !fifo_empty_[data_in] -> WAIT_TILL_EMPTY.
  - data_in==3 is invalid: stay in DECODE_ADDRESS, no write.
- LOAD_FIRST_DATA: lfd_state=1, busy=1 -> LOAD_DATA unconditionally (exactly 1 cycle).
- LOAD_DATA: ld_state=1, write_enb_reg=1, busy=0.
  - fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - fifo_full wins if fifo_full and !pkt_valid arrive in the same cycle.
- FIFO_FULL_STATE: full_state=1, busy=1, write_enb_reg=0.
  - !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL: laf_state=1, busy=1, write_enb_reg=1.
  - parity_done -> DECODE_ADDRESS.
  - !parity_done & low_pkt_valid -> LOAD_PARITY.
  - !parity_done & !low_pkt_valid -> LOAD_DATA.
- LOAD_PARITY: busy=1, write_enb_reg=1 -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: rst_int_reg=1, busy=1.
  - fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: busy=1, write_enb_reg=0.
  - empty_sel -> LOAD_FIRST_DATA; else stay.
- Illegal state encodings -> DECODE_ADDRESS.
- Latency: header accepted in DECODE_ADDRESS to first write_enb_reg is 2 cycles when the FIFO is empty (DECODE -> LFD -> LD).

Optional Feature:
- Macro ROUTER_FSM_TIMEOUT_EN.
- Defined:
  - timer clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - If timer reaches WAIT_LIMIT-1 with empty_sel still 0, next state is DECODE_ADDRESS.
  - drop_pkt pulses 1 for exactly that transition cycle; timer returns to 0.
  - empty_sel=1 in the same cycle as the limit takes precedence (go to LOAD_FIRST_DATA, no drop).
- Undefined: no timer or drop_pkt port; WAIT_TILL_EMPTY waits indefinitely.

Test Plan:
- Reset, then data_in=2'b10, pkt_valid=1, fifo_empty_2=1 -> detect_add=1, then lfd_state=1 (busy=1) one cycle, then ld_state=1 with write_enb_reg=1; pkt_valid=0 -> LOAD_PARITY -> rst_int_reg=1 one cycle -> detect_add=1.
- data_in=2'b01, fifo_empty_1=0 for 5 cycles then 1 -> busy=1, write_enb_reg=0 for 5 cycles, then lfd_state=1.
- In LOAD_DATA assert fifo_full 3 cycles -> full_state=1 for 3 cycles; release with low_pkt_valid=1 -> laf_state one cycle, then LOAD_PARITY.
- In LOAD_DATA with addr_q=2 pulse soft_reset_2 -> next cycle detect_add=1, all load outputs 0; soft_reset_0 pulse instead -> no effect.
- data_in=2'b11 with pkt_valid=1 -> stays DECODE_ADDRESS, write_enb_reg=0; rstn=0 during FIFO_FULL_STATE -> DECODE_ADDRESS at next edge.
- ROUTER_FSM_TIMEOUT_EN, WAIT_LIMIT=30, fifo_empty_0 held 0 -> drop_pkt=1 exactly once after 30 cycles in WAIT_TILL_EMPTY, then detect_add=1.

Source files
------------

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router: header decode, FIFO drain wait, header/payload/parity load, full stalls.
// Optional build macro ROUTER_FSM_TIMEOUT_EN adds a bounded WAIT_TILL_EMPTY with a drop_pkt pulse.
module router_fsm #(
  parameter int WAIT_LIMIT = 30,
  parameter int TMR_W      = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
`ifdef ROUTER_FSM_TIMEOUT_EN
  ,
  output logic       drop_pkt
`endif
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] addr_reg;

  // Address 3 is never a destination; the padding bit keeps every index in range.
  logic [3:0] empty_vec;
  logic [3:0] srst_vec;
  logic       empty_sel;
  logic       srst_sel;
  logic       din_empty;
  logic       din_valid;

  assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign srst_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign empty_sel = empty_vec[addr_reg];
  assign srst_sel  = srst_vec[addr_reg];
  assign din_empty = empty_vec[data_in];
  assign din_valid = pkt_valid && (data_in != 2'd3);

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic [TMR_W-1:0] timer_reg;
  logic             timeout;

  assign timeout = (state_reg == WAIT_TILL_EMPTY) &&
                   (timer_reg == TMR_W'(WAIT_LIMIT - 1)) && !empty_sel;

  // Counts cycles already spent waiting; any exit (or fresh entry) restarts at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer_reg <= '0;
    end else if (state_reg == WAIT_TILL_EMPTY && state_next == WAIT_TILL_EMPTY) begin
      timer_reg <= timer_reg + TMR_W'(1);
    end else begin
      timer_reg <= '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= DECODE_ADDRESS;
      addr_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE_ADDRESS && din_valid) begin
        addr_reg <= data_in;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    busy          = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
    drop_pkt      = 1'b0;
`endif

    case (state_reg)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        if (din_valid) begin
          state_next = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: begin
        lfd_state  = 1'b1;
        busy       = 1'b1;
        state_next = LOAD_DATA;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        if (fifo_full) begin
          state_next = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_next = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
        if (!fifo_full) begin
          state_next = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        busy          = 1'b1;
        write_enb_reg = 1'b1;
        if (parity_done) begin
          state_next = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_next = LOAD_PARITY;
        end else begin
          state_next = LOAD_DATA;
        end
      end
      LOAD_PARITY: begin
        busy          = 1'b1;
        write_enb_reg = 1'b1;
        state_next    = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
        state_next  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (empty_sel) begin
          state_next = LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_TIMEOUT_EN
        end else if (timeout) begin
          state_next = DECODE_ADDRESS;
`endif
        end
      end
      default: state_next = DECODE_ADDRESS;
    endcase

    // A destination soft reset abandons the packet; the FIFO cleans itself up.
    if (srst_sel && state_reg != DECODE_ADDRESS) begin
      state_next = DECODE_ADDRESS;
    end
`ifdef ROUTER_FSM_TIMEOUT_EN
    drop_pkt = timeout && !srst_sel;
`endif
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: each step's expected Moore outputs are queued as the step is driven.
// Timeout scenario runs only when ROUTER_FSM_TIMEOUT_EN is defined.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rstn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg;
`ifdef ROUTER_FSM_TIMEOUT_EN
  logic       drop_pkt;
`endif

  always #5 clk = ~clk;

  router_fsm dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg)
`ifdef ROUTER_FSM_TIMEOUT_EN
    , .drop_pkt(drop_pkt)
`endif
  );

  // Output vector order: busy, detect_add, lfd, ld, laf, full, write_enb, rst_int
  localparam logic [7:0] O_DEC  = 8'b0100_0000;
  localparam logic [7:0] O_LFD  = 8'b1010_0000;
  localparam logic [7:0] O_LD   = 8'b0001_0010;
  localparam logic [7:0] O_FULL = 8'b1000_0100;
  localparam logic [7:0] O_LAF  = 8'b1000_1010;
  localparam logic [7:0] O_LP   = 8'b1000_0010;
  localparam logic [7:0] O_CPE  = 8'b1000_0001;
  localparam logic [7:0] O_WAIT = 8'b1000_0000;

  typedef struct packed {
    logic       rn;
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [7:0] want;
  } step_t;

  step_t      plan_q[$];
  logic [7:0] exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  function automatic stim_t S(logic rn, logic pv, logic [1:0] din, logic ff, logic [2:0] emp,
                              logic [2:0] sr, logic pd, logic lpv);
    S = '{rn: rn, pv: pv, din: din, ff: ff, emp: emp, sr: sr, pd: pd, lpv: lpv};
  endfunction

  function automatic logic [7:0] outs();
    outs = {busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg};
  endfunction

  task automatic plan(stim_t s, logic [7:0] want);
    plan_q.push_back('{s: s, want: want});
  endtask

  task automatic drive(stim_t s);
    rstn = s.rn; pkt_valid = s.pv; data_in = s.din; fifo_full = s.ff;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = s.emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = s.sr;
    parity_done = s.pd; low_pkt_valid = s.lpv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got, want;
    plan(S(0, 1, 2'd1, 1, 3'b000, 3'b111, 1, 1), O_DEC);
    plan(S(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = outs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL reset[%0d] got=%b want=%b", i, got, want); end
`ifdef ROUTER_FSM_TIMEOUT_EN
      n_cmp++;
      if (drop_pkt !== 1'b0) begin n_fail++; $display("FAIL reset_drop[%0d] got=%b want=0", i, drop_pkt); end
`endif
    end
  endtask

  task automatic test_basic_packet();
    logic [7:0] got, want;
    plan(S(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0), O_LFD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LP);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_CPE);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = outs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL basic[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_wait_empty();
    logic [7:0] got, want;
    plan(S(1, 1, 2'd1, 0, 3'b101, 3'b000, 0, 0), O_WAIT);
    // data_in now points at an empty FIFO; only the latched address may matter
    for (int k = 0; k < 4; k++) plan(S(1, 1, 2'd0, 0, 3'b101, 3'b000, 0, 0), O_WAIT);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LFD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LP);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_CPE);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = outs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL wait[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_full_stall();
    logic [7:0] got, want;
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LFD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    for (int k = 0; k < 3; k++) plan(S(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 1), O_LAF);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 1), O_LP);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_CPE);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    // full beats end-of-packet in LOAD_DATA; LAF resumes data; CPE with full re-stalls
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LFD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    plan(S(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LAF);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LP);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_CPE);
    plan(S(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LAF);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 1, 0), O_DEC);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = outs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL full[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_soft_reset();
    logic [7:0] got, want;
    plan(S(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0), O_LFD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b001, 0, 0), O_LD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b100, 0, 0), O_DEC);
    // soft reset has no effect while already decoding
    plan(S(1, 1, 2'd2, 0, 3'b111, 3'b100, 0, 0), O_LFD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b011, 0, 0), O_LD);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LP);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_CPE);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = outs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL soft_reset[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_invalid_and_rst();
    logic [7:0] got, want;
    plan(S(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    plan(S(1, 1, 2'd3, 0, 3'b000, 3'b000, 0, 0), O_DEC);
    plan(S(1, 0, 2'd1, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    plan(S(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0), O_LFD);
    plan(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    plan(S(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_FULL);
    plan(S(0, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0), O_DEC);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = outs(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL invalid_rst[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

`ifdef ROUTER_FSM_TIMEOUT_EN
  task automatic test_timeout();
    logic [8:0] got, want;
    int         drops = 0;
    // Run A: FIFO 0 never drains; drop on the 30th waiting cycle, then decode.
    plan(S(1, 1, 2'd0, 0, 3'b110, 3'b000, 0, 0), O_WAIT);
    for (int k = 1; k < 30; k++) plan(S(1, 0, 2'd0, 0, 3'b110, 3'b000, 0, 0), O_WAIT);
    plan(S(1, 0, 2'd0, 0, 3'b110, 3'b000, 0, 0), O_DEC);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = {drop_pkt, outs()}; want = {(i == 29), exp_q.pop_front()}; n_cmp++;
      drops += int'(drop_pkt);
      if (got !== want) begin n_fail++; $display("FAIL timeout[%0d] got=%b want=%b", i, got, want); end
    end
    n_cmp++;
    if (drops != 1) begin n_fail++; $display("FAIL timeout_count got=%0d want=1", drops); end
    // Run B: FIFO drains exactly at the limit cycle; load wins, no drop.
    plan(S(1, 1, 2'd0, 0, 3'b110, 3'b000, 0, 0), O_WAIT);
    for (int k = 1; k < 30; k++) plan(S(1, 0, 2'd0, 0, 3'b110, 3'b000, 0, 0), O_WAIT);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = {1'b0, outs()}; want = {1'b0, exp_q.pop_front()}; n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL timeout_b[%0d] got=%b want=%b", i, got, want); end
    end
    drive(S(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0));
    #1;
    n_cmp++;
    if (drop_pkt !== 1'b0) begin n_fail++; $display("FAIL timeout_prec got=%b want=0", drop_pkt); end
    exp_q.push_back(O_LFD); tick();
    got = {drop_pkt, outs()}; want = {1'b0, exp_q.pop_front()}; n_cmp++;
    if (got !== want) begin n_fail++; $display("FAIL timeout_lfd got=%b want=%b", got, want); end
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LD);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_LP);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_CPE);
    plan(S(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0), O_DEC);
    for (int i = 0; plan_q.size() > 0; i++) begin
      step_t st = plan_q.pop_front();
      drive(st.s); exp_q.push_back(st.want); tick();
      got = {1'b0, outs()}; want = {1'b0, exp_q.pop_front()}; n_cmp++;
      if (got !== want) begin n_fail++; $display("FAIL timeout_tail[%0d] got=%b want=%b", i, got, want); end
    end
  endtask
`endif

  initial begin
    drive(S(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0));
    test_reset();
    test_basic_packet();
    test_wait_empty();
    test_full_stall();
    test_soft_reset();
    test_invalid_and_rst();
`ifdef ROUTER_FSM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
